// File: rtl/hex_seq_pkg.sv
// Shared state encoding, counter width and dwell compare selection for the
// hex digit sequencer.
package hex_seq_pkg;

   localparam int CNT_W = 24;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP
   } state_t;

   // A zero configuration falls back to the build-time default dwell.
   function automatic logic [CNT_W-1:0] select_cmp(
      input logic [7:0]       cfg,
      input logic [CNT_W-1:0] dflt
   );
      return (cfg == 8'd0) ? dflt : {6'b0, cfg, 10'b0};
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..cmp and pulses expire for the cycle it sits at cmp,
// returning to zero on the following cycle.
module dwell_timer
   import hex_seq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [CNT_W-1:0] cmp,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   assign expire = (count == cmp);

   always_ff @(posedge clk) begin
      if (reset || clear || expire)
         count <= '0;
      else
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/hex_digit_sequencer.sv
// Shows a 16-bit result one hex nibble at a time, MSB first, with a blank gap
// between words. Define HEXSEQ_LOOP_EN to repeat the word instead of gapping.
module hex_digit_sequencer
   import hex_seq_pkg::*;
#(
   parameter logic [CNT_W-1:0] DWELL_COUNT = 24'd10_000_000,
   parameter int               NUM_DIGITS  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4*NUM_DIGITS-1:0]       data_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   input  logic [7:0]                    dwell_cfg,
   output logic [3:0]                    digit,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          blank,
   output logic                          busy,
   output logic                          done
);

   localparam int              IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_t                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] word_q;
   logic [CNT_W-1:0]        cmp_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    expire;
   logic                    last_nibble;
   logic                    transfer;
   logic                    timer_clear;

   assign last_nibble = (state_q == SHOW) && (idx_q == LAST_IDX) && expire;
   assign transfer    = data_valid && data_ready;
   assign timer_clear = transfer || (state_q == IDLE);
   assign digit_idx   = idx_q;

   dwell_timer u_dwell_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .cmp    (cmp_q),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (transfer) state_d = SHOW;
`ifdef HEXSEQ_LOOP_EN
         SHOW:    state_d = SHOW;
`else
         SHOW:    if (last_nibble) state_d = GAP;
`endif
         GAP:     if (expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Word and dwell are latched once per transfer so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= '0;
         cmp_q  <= '0;
         idx_q  <= '0;
      end else if (transfer) begin
         word_q <= data_in;
         cmp_q  <= select_cmp(dwell_cfg, DWELL_COUNT);
         idx_q  <= '0;
      end else if (state_q == SHOW && expire) begin
         idx_q  <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_comb begin
      data_ready = 1'b0;
      blank      = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      digit      = '0;
      case (state_q)
         IDLE: data_ready = 1'b1;
         SHOW: begin
            blank = 1'b0;
            busy  = 1'b1;
            done  = last_nibble;
`ifdef HEXSEQ_LOOP_EN
            data_ready = last_nibble;
`else
            data_ready = 1'b0;
`endif
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (idx_q == IDX_W'(i))
                  digit = word_q[4*(NUM_DIGITS-1-i) +: 4];
            end
         end
         GAP:     busy = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Directed bench for hex_digit_sequencer with a short default dwell of 3.
// Covers the HEXSEQ_LOOP_EN build when that macro is defined.
module tb_hex_digit_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic        data_valid;
   logic        data_ready;
   logic [7:0]  dwell_cfg;
   logic [3:0]  digit;
   logic [1:0]  digit_idx;
   logic        blank;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   hex_digit_sequencer #(
      .DWELL_COUNT (24'd3),
      .NUM_DIGITS  (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .dwell_cfg  (dwell_cfg),
      .digit      (digit),
      .digit_idx  (digit_idx),
      .blank      (blank),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic valid,
                                input logic [15:0] data, input logic [7:0] cfg);
      reset      = rst;
      data_valid = valid;
      data_in    = data;
      dwell_cfg  = cfg;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_ready"}, 32'(data_ready), 32'd1);
      checkOutput({tag, "_blank"}, 32'(blank), 32'd1);
      checkOutput({tag, "_busy"},  32'(busy),  32'd0);
      checkOutput({tag, "_done"},  32'(done),  32'd0);
      checkOutput({tag, "_digit"}, 32'(digit), 32'd0);
      checkOutput({tag, "_idx"},   32'(digit_idx), 32'd0);
   endtask

   task automatic waitReady();
      int n = 0;
      while (!data_ready && n < 100) begin
         tick();
         n++;
      end
      if (!data_ready) checkOutput("ready_timeout", 32'(data_ready), 32'd1);
   endtask

   // Offers word in the current cycle T, then walks every cycle up to T+5*hold+1.
   // After the transfer, post_* inputs are driven to show they are ignored.
   task automatic runWord(input string tag, input logic [15:0] word,
                          input logic [7:0] cfg, input int hold,
                          input logic post_valid, input logic [15:0] post_data,
                          input logic [7:0] post_cfg);
      int nib;
      logic [3:0] exp_digit;
      waitReady();
      applyStimulus(1'b0, 1'b1, word, cfg);
      checkOutput({tag, "_ready_T"}, 32'(data_ready), 32'd1);
      tick();
      applyStimulus(1'b0, post_valid, post_data, post_cfg);
      for (int c = 1; c <= 5*hold; c++) begin
         if (c > 1) tick();
         if (c <= 4*hold) begin
            nib       = (c - 1) / hold;
            exp_digit = word[15-4*nib -: 4];
            checkOutput({tag, "_digit"}, 32'(digit), 32'(exp_digit));
            checkOutput({tag, "_idx"},   32'(digit_idx), 32'(nib));
            checkOutput({tag, "_blank"}, 32'(blank), 32'd0);
            checkOutput({tag, "_done"},  32'(done), (c == 4*hold) ? 32'd1 : 32'd0);
         end else begin
            checkOutput({tag, "_gap_blank"}, 32'(blank), 32'd1);
            checkOutput({tag, "_gap_done"},  32'(done), 32'd0);
         end
         checkOutput({tag, "_busy"},  32'(busy), 32'd1);
         checkOutput({tag, "_ready"}, 32'(data_ready), 32'd0);
      end
      tick();
      checkOutput({tag, "_ready_end"}, 32'(data_ready), 32'd1);
      checkOutput({tag, "_busy_end"},  32'(busy), 32'd0);
      checkOutput({tag, "_blank_end"}, 32'(blank), 32'd1);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
      tick();
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      checkIdle("reset");

`ifdef HEXSEQ_LOOP_EN
      applyStimulus(1'b0, 1'b1, 16'hBEEF, 8'h00);
      checkOutput("loop_ready_T", 32'(data_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      for (int c = 1; c <= 48; c++) begin
         logic [15:0] w;
         int nib;
         if (c > 1) tick();
         w   = 16'hBEEF;
         nib = ((c - 1) / 4) % 4;
         checkOutput("loop_digit", 32'(digit), 32'(w[15-4*nib -: 4]));
         checkOutput("loop_idx",   32'(digit_idx), 32'(nib));
         checkOutput("loop_done",  32'(done), (c % 16 == 0) ? 32'd1 : 32'd0);
         checkOutput("loop_ready", 32'(data_ready), (c % 16 == 0) ? 32'd1 : 32'd0);
         checkOutput("loop_busy",  32'(busy), 32'd1);
      end
      applyStimulus(1'b0, 1'b1, 16'h0102, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      checkOutput("loop_new_digit", 32'(digit), 32'h0);
      checkOutput("loop_new_idx",   32'(digit_idx), 32'd0);
      for (int k = 0; k < 4; k++) tick();
      checkOutput("loop_new_digit1", 32'(digit), 32'h1);
      checkOutput("loop_new_idx1",   32'(digit_idx), 32'd1);
      applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      checkIdle("loop_reset");
`else
      runWord("basic", 16'hA5C3, 8'h00, 4, 1'b0, 16'hDEAD, 8'h00);
      runWord("bp_first", 16'hA5C3, 8'h00, 4, 1'b1, 16'h1234, 8'h00);
      runWord("bp_second", 16'h1234, 8'h00, 4, 1'b0, 16'h0000, 8'h00);
      runWord("zero", 16'h0000, 8'h00, 4, 1'b0, 16'h0000, 8'h00);
      runWord("ones", 16'hFFFF, 8'h00, 4, 1'b0, 16'h0000, 8'h00);
      runWord("cfg", 16'h9E71, 8'h01, 1025, 1'b0, 16'h0000, 8'h02);

      // Reset during nibble 2 while another word is offered.
      applyStimulus(1'b0, 1'b1, 16'h6B2D, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      for (int k = 1; k < 9; k++) tick();
      checkOutput("mid_idx", 32'(digit_idx), 32'd2);
      checkOutput("mid_digit", 32'(digit), 32'h2);
      applyStimulus(1'b1, 1'b1, 16'h7777, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      checkIdle("mid_reset");

      // Reset beats a simultaneous transfer in IDLE.
      applyStimulus(1'b1, 1'b1, 16'h7777, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      checkIdle("rst_xfer");
      tick();
      checkIdle("rst_xfer_after");

      runWord("after_rst", 16'h3C0F, 8'h00, 4, 1'b0, 16'h0000, 8'h00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
